// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter.
// Holds the FSM state encoding and the full-word byte-enable constant.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_e;

  localparam logic [3:0] BE_FULL = 4'b1111;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between fetch/data requesters, arbiter and memory.
// master: arbiter view; slave: requesters plus memory (environment).
interface mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_width;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_width;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  i_req, i_addr,
    output i_ack, i_rdata,
    input  d_req, d_we, d_addr,
    input  d_wdata, d_width,
    output d_ack, d_rdata,
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_width,
    input  mem_rvalid, mem_rdata
  );

  modport slave (
    output i_req, i_addr,
    input  i_ack, i_rdata,
    output d_req, d_we, d_addr,
    output d_wdata, d_width,
    input  d_ack, d_rdata,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_width,
    output mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/starve_counter.sv
// Counts data grants made while fetch waits; requests a forced fetch
// grant at LIMIT. Ports: clk, rst, grants in, fetch_req_i, force_fetch_o.
module starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic data_grant_i,
  input  logic fetch_grant_i,
  input  logic fetch_req_i,
  output logic force_fetch_o
);

  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (fetch_grant_i) begin
      cnt_d = '0;
    end else if (data_grant_i) begin
      cnt_d = fetch_req_i ? cnt_q + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign force_fetch_o =
    fetch_req_i && (cnt_q == 3'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Data-priority arbiter, one outstanding memory transaction.
// Ports: clk, rst (sync, active-high), bus (mem_arbiter_if.master).
// Optional fetch starvation guard: ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
    $error("STARVE_LIMIT out of range 1..7");
  end

  state_e state_q, state_d;

  logic              grant_i, grant_d;
  logic              force_i;
  logic              i_ack, d_ack;
  logic [DATA_W-1:0] i_rdata, d_rdata;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_width;

`ifdef ARB_STARVE_GUARD_EN
  starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk          (clk),
    .rst          (rst),
    .data_grant_i (grant_d),
    .fetch_grant_i(grant_i),
    .fetch_req_i  (bus.i_req),
    .force_fetch_o(force_i)
  );
`else
  assign force_i = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_width = '0;

    unique case (state_q)
      IDLE: begin
        // mem_rvalid is deliberately ignored here
        if (bus.d_req && !force_i) grant_d = 1'b1;
        else if (bus.i_req)        grant_i = 1'b1;
      end
      WAIT_I: begin
        if (bus.mem_rvalid) begin
          i_ack   = 1'b1;
          i_rdata = bus.mem_rdata;
          state_d = IDLE;
        end
      end
      WAIT_D: begin
        if (bus.mem_rvalid) begin
          d_ack   = 1'b1;
          d_rdata = bus.mem_rdata;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset wins: abandon any transaction, keep the bus quiet
    if (rst) begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      i_ack   = 1'b0;
      d_ack   = 1'b0;
      i_rdata = '0;
      d_rdata = '0;
      state_d = IDLE;
    end

    if (grant_d) begin
      mem_req   = 1'b1;
      mem_we    = bus.d_we;
      mem_addr  = bus.d_addr;
      mem_wdata = bus.d_wdata;
      mem_width = bus.d_width;
      state_d   = WAIT_D;
    end else if (grant_i) begin
      mem_req   = 1'b1;
      mem_addr  = bus.i_addr;
      mem_width = BE_FULL;
      state_d   = WAIT_I;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign bus.i_ack     = i_ack;
  assign bus.i_rdata   = i_rdata;
  assign bus.d_ack     = d_ack;
  assign bus.d_rdata   = d_rdata;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_width = mem_width;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a latency-programmable memory.
// Works with and without ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  typedef struct {
    logic          dat;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [3:0]    be;
    logic [DW-1:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  bit   cur_v;
  int   g_hist[$];
  int   total = 0;
  int   bad = 0;
  int   cyc_n = 0;
  int   g_cyc, a_cyc;

  bit            pend, stray, zchk;
  int            cnt, lat;
  logic [DW-1:0] rval;
  int            d_left;

  task automatic check(string tag, logic [127:0] got,
                       logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_fn(logic [AW-1:0] a);
    if (a == 10'h334) return 32'h0000_0013;
    return 32'hA5A5_0000 | 32'(a);
  endfunction

  function automatic txn_t mk(logic dat, logic [AW-1:0] a,
                              logic we, logic [DW-1:0] wd,
                              logic [3:0] be);
    txn_t t;
    t.dat = dat; t.addr = a; t.we = we;
    t.wdata = wd; t.be = be; t.rdata = mem_fn(a);
    return t;
  endfunction

  task automatic cyc();
    bit busy, rv;
    rv = stray || (pend && cnt == 0);
    bus.mem_rvalid = rv;
    bus.mem_rdata  = rv ? (stray ? 32'hBAD0_BAD0 : rval) : '0;
    #1;
    busy = cur_v;
    if (zchk)
      check("all_zero",
            {bus.i_ack, bus.i_rdata, bus.d_ack, bus.d_rdata,
             bus.mem_req, bus.mem_we, bus.mem_addr,
             bus.mem_wdata, bus.mem_width}, '0);
    if (!bus.mem_req)
      check("bus_idle", {bus.mem_we, bus.mem_addr,
            bus.mem_wdata, bus.mem_width}, '0);
    if (!bus.i_ack) check("i_rdata0", bus.i_rdata, '0);
    if (!bus.d_ack) check("d_rdata0", bus.d_rdata, '0);
    if (busy) begin
      check("req_busy", bus.mem_req, 0);
      check("ack_on_rv", bus.i_ack | bus.d_ack, rv);
    end
    if (bus.i_ack || bus.d_ack) begin
      if (!busy) begin
        check("spur_ack", {bus.i_ack, bus.d_ack}, 0);
      end else begin
        a_cyc = cyc_n;
        check("ack_kind", {bus.i_ack, bus.d_ack},
              cur.dat ? 2'b01 : 2'b10);
        check("ack_rdata", cur.dat ? bus.d_rdata : bus.i_rdata,
              cur.rdata);
        if (lat == 1) check("ack_lat", a_cyc - g_cyc, 1);
        cur_v = 0;
        if (bus.i_ack) bus.i_req = 1'b0;
        if (bus.d_ack) begin
          d_left--;
          if (d_left <= 0) bus.d_req = 1'b0;
        end
      end
    end
    if (!stray) begin
      if (rv) pend = 0;
      else if (pend) cnt--;
    end
    stray = 0;
    if (!busy && bus.mem_req) begin
      if (exp_q.size() == 0) begin
        check("extra_grant", bus.mem_req, 0);
      end else begin
        cur = exp_q.pop_front();
        cur_v = 1;
        g_cyc = cyc_n;
        g_hist.push_back(cyc_n);
        check(cur.dat ? "grant_d" : "grant_i",
              {bus.mem_we, bus.mem_addr, bus.mem_wdata,
               bus.mem_width},
              {cur.we, cur.addr, cur.wdata, cur.be});
        pend = 1;
        cnt  = lat - 1;
        rval = mem_fn(bus.mem_addr);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic run(int budget);
    int n = 0;
    while ((exp_q.size() != 0 || cur_v) && n < budget) begin
      cyc();
      n++;
    end
    check("timeout", exp_q.size() + int'(cur_v), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0;
    bus.d_wdata = '0; bus.d_width = '0;
    bus.mem_rvalid = 0; bus.mem_rdata = '0;
    pend = 0; stray = 0; zchk = 0; cur_v = 0;
    lat = 1; d_left = 0;
    @(negedge clk);
    zchk = 1;
    cyc();
    cyc();
    zchk = 0;
    rst = 1'b0;

    // fetch only
    bus.i_req = 1; bus.i_addr = 10'h334;
    exp_q.push_back(mk(0, 10'h334, 0, '0, 4'hF));
    run(20);

    // collision: data first, fetch at N+2
    g_hist.delete();
    bus.i_req = 1; bus.i_addr = 10'h0A0;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 10'h010;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_width = 4'b0011;
    d_left = 1;
    exp_q.push_back(mk(1, 10'h010, 1, 32'hDEAD_BEEF, 4'b0011));
    exp_q.push_back(mk(0, 10'h0A0, 0, '0, 4'hF));
    run(20);
    check("coll_gap", g_hist[1] - g_hist[0], 2);

    // starvation: data held high with fetch waiting
    bus.i_req = 1; bus.i_addr = 10'h100;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 10'h020;
    bus.d_wdata = 32'h1111_2222; bus.d_width = 4'hF;
    d_left = 6;
`ifdef ARB_STARVE_GUARD_EN
    for (int k = 0; k < 4; k++)
      exp_q.push_back(mk(1, 10'h020, 0, 32'h1111_2222, 4'hF));
    exp_q.push_back(mk(0, 10'h100, 0, '0, 4'hF));
    for (int k = 0; k < 2; k++)
      exp_q.push_back(mk(1, 10'h020, 0, 32'h1111_2222, 4'hF));
`else
    for (int k = 0; k < 6; k++)
      exp_q.push_back(mk(1, 10'h020, 0, 32'h1111_2222, 4'hF));
    exp_q.push_back(mk(0, 10'h100, 0, '0, 4'hF));
`endif
    run(100);

    // reset in WAIT_D, completion arrives after reset
    lat = 2;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 10'h055;
    bus.d_wdata = 32'h1234_5678; bus.d_width = 4'b1100;
    d_left = 1;
    exp_q.push_back(mk(1, 10'h055, 1, 32'h1234_5678, 4'b1100));
    cyc();
    check("rst_granted", int'(cur_v), 1);
    rst = 1; bus.d_req = 0; cur_v = 0;
    zchk = 1;
    cyc();
    rst = 0;
    cyc();
    zchk = 0;
    check("rst_rv_used", int'(pend), 0);
    lat = 1;

    // stray completion in IDLE
    stray = 1; zchk = 1;
    cyc();
    zchk = 0;
    bus.i_req = 1; bus.i_addr = 10'h200;
    exp_q.push_back(mk(0, 10'h200, 0, '0, 4'hF));
    run(20);

    // variable latency
    lat = 6;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 10'h3FF;
    bus.d_wdata = '0; bus.d_width = 4'b0101;
    d_left = 1;
    exp_q.push_back(mk(1, 10'h3FF, 0, '0, 4'b0101));
    run(50);
    check("vl_gap", a_cyc - g_cyc, 6);
    lat = 1;

    // request dropped after grant still completes
    bus.i_req = 1; bus.i_addr = 10'h077;
    exp_q.push_back(mk(0, 10'h077, 0, '0, 4'hF));
    cyc();
    bus.i_req = 0;
    run(20);
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, memory word-address/byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive data grants allowed while fetch waits (1..7).
REQ-004 SHALL have ports: clk  in  1  clock, all logic on rising edge; rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: i_req in 1 fetch request; i_addr in ADDR_W fetch address; i_ack out 1 fetch complete; i_rdata out DATA_W fetch data.
REQ-006 SHALL have ports: d_req in 1 data request; d_we in 1 store; d_addr in ADDR_W; d_wdata in DATA_W; d_width in 4 byte enables; d_ack out 1; d_rdata out DATA_W.
REQ-007 SHALL have ports: mem_req out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_width out 4; mem_rvalid in 1 completion; mem_rdata in DATA_W.

Function
REQ-008 SHALL implement FSM states IDLE, WAIT_I, WAIT_D; one outstanding memory transaction max.
REQ-009 In IDLE with any request, SHALL assert mem_req for that single cycle, drive mem_* from winner, and enter WAIT_I/WAIT_D at next edge.
REQ-010 Arbitration SHALL be data-priority: d_req wins over i_req unless starvation override (REQ-017) is active.
REQ-011 For fetch grants SHALL drive mem_we=0, mem_width=4'b1111, mem_wdata=0.
REQ-012 mem_req SHALL be 0 in WAIT_I/WAIT_D; mem_* fields SHALL be 0 when mem_req=0.
REQ-013 In WAIT_x with mem_rvalid=1, SHALL assert x_ack for exactly that cycle, drive x_rdata=mem_rdata, return to IDLE; stores also complete via mem_rvalid.
REQ-014 i_rdata/d_rdata SHALL be 0 whenever the corresponding ack is 0.
REQ-015 Minimum latency: grant cycle N, ack cycle N+1; next grant no earlier than N+2.
REQ-016 mem_rvalid in IDLE SHALL be ignored; requesters hold req and fields until ack; a request dropped before ack still completes and acks.

Reset
REQ-018 On rst: state IDLE, all acks 0, mem_req 0, all mem_* and rdata outputs 0, starvation counter 0.
REQ-019 rst during WAIT_x SHALL abandon the transaction; no ack issued; late mem_rvalid ignored.

Configuration
REQ-017 With ARB_STARVE_GUARD_EN defined: a counter increments on each data grant made while i_req=1, clears on fetch grant or on data grant with i_req=0; when counter==STARVE_LIMIT and i_req=1, next grant SHALL go to fetch. Without the macro: strict data priority, no counter logic.

Structure
REQ-020 Package mem_arb_pkg SHALL hold the FSM state encoding and the full-word byte-enable constant 4'b1111.
REQ-021 Starvation counter SHALL be sub-module starve_counter, instantiated only under ARB_STARVE_GUARD_EN.

Verification
REQ-022 Fetch only: i_req=1, i_addr=0x334, mem_rvalid next cycle with mem_rdata=0x00000013 -> mem_req one cycle, mem_addr=0x334, i_ack=1 and i_rdata=0x00000013 cycle N+1.
REQ-023 Collision: i_req=d_req=1 same cycle, d_we=1, d_addr=0x010, d_wdata=0xDEADBEEF, d_width=4'b0011 -> data issued first with those fields; fetch issued at N+2.
REQ-024 Starvation (macro on, STARVE_LIMIT=4): d_req and i_req held high -> 4 data grants, 5th grant fetch, then data resumes; macro off -> fetch never granted while d_req high.
REQ-025 Reset mid-op: rst in WAIT_D, mem_rvalid one cycle later -> d_ack stays 0, state IDLE, all outputs 0.
REQ-026 Stray completion: mem_rvalid=1 in IDLE with no requests -> no ack, no state change.
REQ-027 Variable latency: mem_rvalid delayed 5 cycles -> mem_req remains 0, ack exactly once on the rvalid cycle.
